// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between an SPI slave and spi_ram_ctrl.
//   din      : 10-bit command word, [9:8] opcode, [7:0] payload
//   rx_valid : command word valid (level; a command is taken on its rising edge)
//   dout     : read data returned for shift-out
//   tx_valid : dout valid, held for a fixed number of cycles per read
// Modports: master = SPI slave side (issues commands), slave = RAM controller.
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port synchronous RAM with a 2-bit-opcode command decoder, sitting behind an SPI slave.
// Commands (taken only on a rising edge of rx_valid):
//   00 : set write address      01 : write payload at write address
//   10 : set read address       11 : read mem[read address] into dout (payload ignored)
// A read raises tx_valid for exactly TX_HOLD cycles; dout keeps its value afterwards.
// Any accepted command during a hold aborts it (11 restarts it with fresh data).
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (RAM contents are not reset)
//   bus   : spi_ram_ctrl_if.slave (din, rx_valid in; dout, tx_valid out)
//
// Parameters:
//   MEM_DEPTH : number of 8-bit words, power of 2, at most 256
//   ADDR_SIZE : log2(MEM_DEPTH)
//   TX_HOLD   : tx_valid high time per read, at least 9
//
// Optional feature, macro SPI_RAM_ADDR_AUTO_INC_EN: when defined, the write pointer advances after
// every accepted 01 and the read pointer after every accepted 11, wrapping modulo MEM_DEPTH.
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TX_HOLD   = 9
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(TX_HOLD);
  localparam logic [CntW-1:0] CntLoad = CntW'(TX_HOLD - 1);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] AddrOne = ADDR_SIZE'(1);
`endif

  typedef enum logic [1:0] {
    OpWrAddr = 2'b00,
    OpWrData = 2'b01,
    OpRdAddr = 2'b10,
    OpRdData = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic [7:0]            dout_q, dout_d;
  logic                  rx_valid_q;

  logic                  accept;
  op_e                   op;
  logic [ADDR_SIZE-1:0]  cmd_addr;
  logic                  mem_we;

  logic [7:0] mem [MEM_DEPTH];

  // A level-high rx_valid must not re-execute: only the 0->1 transition qualifies.
  assign accept   = bus.rx_valid & ~rx_valid_q;
  assign op       = op_e'(bus.din[9:8]);
  assign cmd_addr = bus.din[ADDR_SIZE-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;

    // Hold countdown; a command accepted this cycle overrides it below.
    if (state_q == StHold) begin
      if (cnt_q == '0) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (accept) begin
      unique case (op)
        OpWrAddr: begin
          wr_addr_d = cmd_addr;
          state_d   = StIdle;
          cnt_d     = '0;
        end
        OpWrData: begin
          mem_we  = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
          wr_addr_d = wr_addr_q + AddrOne;
`endif
          state_d = StIdle;
          cnt_d   = '0;
        end
        OpRdAddr: begin
          rd_addr_d = cmd_addr;
          state_d   = StIdle;
          cnt_d     = '0;
        end
        OpRdData: begin
          dout_d  = mem[rd_addr_q];
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
          rd_addr_d = rd_addr_q + AddrOne;
`endif
          state_d = StHold;
          cnt_d   = CntLoad;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      rx_valid_q <= bus.rx_valid;
    end
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= bus.din[7:0];
    end
  end

  assign bus.dout     = dout_q;
  // Decoded from the state register so an asynchronous reset drops it immediately.
  assign bus.tx_valid = (state_q == StHold);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus a randomized command stream,
// all checked against a behavioural model (byte array plus two pointers).
module tb_spi_ram_ctrl;

  localparam int unsigned TxHold = 9;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_ram_ctrl_if bus();

  spi_ram_ctrl #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8),
    .TX_HOLD  (TxHold)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] m_dout;

  function automatic void model_cmd(input logic [9:0] w);
    case (w[9:8])
      2'b00: m_wr = w[7:0];
      2'b01: begin
        m_mem[m_wr] = w[7:0];
        if (AutoInc) m_wr = m_wr + 8'd1;
      end
      2'b10: m_rd = w[7:0];
      default: begin
        m_dout = m_mem[m_rd];
        if (AutoInc) m_rd = m_rd + 8'd1;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: raise rx_valid with word w, check outputs one cycle after the edge,
  // keep rx_valid high for `high` cycles in total, then low for `low` cycles.
  task automatic cmd(input logic [9:0] w, input int high, input int low, input string tag);
    bus.din      = w;
    bus.rx_valid = 1'b1;
    model_cmd(w);
    @(negedge clk);
    chk({tag, "_txv"}, 16'(bus.tx_valid), 16'(w[9:8] == 2'b11));
    chk({tag, "_dout"}, 16'(bus.dout), 16'(m_dout));
    repeat (high - 1) @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  // Read command and full check of the hold window: high for TxHold samples, then low.
  task automatic read_hold(input string tag);
    cmd(10'h300, 1, 0, tag);
    for (int i = 2; i <= TxHold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 16'(bus.tx_valid), 16'd1);
    end
    @(negedge clk);
    chk({tag, "_drop"}, 16'(bus.tx_valid), 16'd0);
    chk({tag, "_keep"}, 16'(bus.dout), 16'(m_dout));
  endtask

  logic [7:0] exp_seq [3];
  logic [1:0] r_op;
  logic [7:0] r_pay;

  initial begin
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    m_wr   = '0;
    m_rd   = '0;
    m_dout = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_dout", 16'(bus.dout), 16'h00);
    chk("reset_txv", 16'(bus.tx_valid), 16'd0);

    // Fill the whole RAM with random bytes so every later read has a known value.
    for (int a = 0; a < 256; a++) begin
      cmd({2'b00, 8'(a)}, 1, 1, "init_wa");
      cmd({2'b01, 8'($urandom)}, 1, 1, "init_wd");
    end

    // Basic write then read.
    cmd(10'h0A5, 3, 1, "basic_wa");
    cmd(10'h13C, 3, 1, "basic_wd");
    cmd(10'h2A5, 3, 1, "basic_ra");
    read_hold("basic_rd");
    chk("basic_val", 16'(bus.dout), 16'h3C);
    repeat (5) @(negedge clk);
    chk("basic_stay", 16'(bus.dout), 16'h3C);

    // Long rx_valid level must write only once.
    cmd(10'h010, 1, 1, "lvl_wa");
    cmd(10'h13C, 20, 1, "lvl_wd");
    cmd(10'h210, 1, 1, "lvl_ra");
    read_hold("lvl_rd0");
    chk("lvl_val", 16'(bus.dout), 16'h3C);
    cmd(10'h211, 1, 1, "lvl_ra1");
    read_hold("lvl_rd1");
    cmd(10'h010, 1, 1, "ovr_wa");
    cmd(10'h1FF, 1, 1, "ovr_wd");
    cmd(10'h210, 1, 1, "ovr_ra");
    read_hold("ovr_rd");
    chk("ovr_val", 16'(bus.dout), 16'hFF);

    // Abort a hold in its 4th cycle with a write-address command.
    cmd(10'h220, 1, 1, "abt_ra");
    cmd(10'h300, 1, 0, "abt_rd");
    repeat (3) @(negedge clk);
    chk("abt_c4", 16'(bus.tx_valid), 16'd1);
    bus.din      = 10'h0FF;
    bus.rx_valid = 1'b1;
    model_cmd(10'h0FF);
    @(negedge clk);
    chk("abt_drop", 16'(bus.tx_valid), 16'd0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    cmd(10'h1A7, 1, 1, "abt_wd");
    cmd(10'h2FF, 1, 1, "abt_ra2");
    read_hold("abt_rd2");
    chk("abt_wraddr", 16'(bus.dout), 16'hA7);

    // Back-to-back reads: the second restarts the full hold.
    cmd(10'h230, 1, 1, "b2b_ra");
    cmd(10'h300, 1, 1, "b2b_rd0");
    read_hold("b2b_rd1");

    // Streaming pattern (pointer behaviour depends on the auto-increment build).
    cmd(10'h0FE, 1, 1, "str_wa");
    cmd(10'h111, 1, 1, "str_w0");
    cmd(10'h122, 1, 1, "str_w1");
    cmd(10'h133, 1, 1, "str_w2");
    cmd(10'h2FE, 1, 1, "str_ra");
    if (AutoInc) exp_seq = '{8'h11, 8'h22, 8'h33};
    else         exp_seq = '{8'h33, 8'h33, 8'h33};
    for (int i = 0; i < 3; i++) begin
      read_hold("str_rd");
      chk("str_val", 16'(bus.dout), 16'(exp_seq[i]));
    end

    // Randomized command stream.
    for (int n = 0; n < 300; n++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_pay = 8'($urandom);
      cmd({r_op, r_pay}, int'($urandom_range(1, 3)), int'($urandom_range(1, 2)), "rnd");
    end

    // Asynchronous reset in the middle of a hold.
    cmd(10'h240, 1, 1, "rst_ra");
    cmd(10'h300, 1, 0, "rst_rd");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_txv", 16'(bus.tx_valid), 16'd0);
    chk("rst_async_dout", 16'(bus.dout), 16'h00);
    m_wr   = '0;
    m_rd   = '0;
    m_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_txv", 16'(bus.tx_valid), 16'd0);
    chk("rst_dout", 16'(bus.dout), 16'h00);
    // RAM survives reset; read pointer is back at 0.
    read_hold("rst_rd0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
